md5_batch_ctrl: RTL and testbench
=================================

MD5_BATCH_CTRL -- requirements
Module: md5_batch_ctrl

Interface
REQ-001 Parameter MSG_LEN, default 19, is the number of match characters read out per matched string.
REQ-002 Parameter DONE_TIMEOUT, default 1024, is the maximum cycles spent in WAIT_DONE; legal range 1..65535.
REQ-003 Port clk  input  1  is the single clock; all logic is rising-edge.
REQ-004 Port reset  input  1  is a synchronous, active-high reset.
REQ-005 Host side ports SHALL be:
- batch_start  in  1  start pulse.
- batch_num_bytes  in  16  batch length.
- batch_busy  out  1  batch in progress.
- batch_done  out  1  one-cycle completion pulse.
- batch_match  out  1  match found.
- batch_timeout  out  1  WAIT_DONE expired.
- batch_byte_pos  out  16  byte position.
REQ-006 Byte source ports SHALL be src_data  in  8, src_valid  in  1 and src_ready  out  1, forming a valid/ready stream.
REQ-007 Result ports SHALL be res_char  out  8, res_valid  out  1 and res_ready  in  1, forming a valid/ready stream.
REQ-008 Processor side ports SHALL be proc_start, proc_num_bytes[15:0], proc_data[7:0], proc_data_valid and proc_match_char_next as outputs, and proc_done, proc_match, proc_byte_pos[15:0] and proc_match_char[7:0] as inputs.

Function
REQ-009 The FSM SHALL have states IDLE, START, STREAM, WAIT_DONE, READOUT and FINISH.
REQ-010 IDLE: batch_start=1 SHALL latch batch_num_bytes into N, clear the flags and enter START; batch_start outside IDLE SHALL be ignored.
REQ-011 START: the block SHALL assert proc_start=1 with proc_num_bytes=N for exactly one cycle, then enter STREAM if N>0, else WAIT_DONE.
REQ-012 STREAM: src_ready SHALL be 1.
- Each src_valid&src_ready cycle SHALL register src_data onto proc_data with proc_data_valid=1 on the next cycle (1-cycle latency).
- Otherwise proc_data_valid SHALL be 0 and proc_data SHALL hold its value.
REQ-013 STREAM: the sent-byte counter SHALL increment per accepted byte; on accepting byte N the FSM SHALL enter WAIT_DONE and src_ready SHALL drop on the following cycle.
REQ-014 src_ready SHALL be 0 in every state except STREAM.
REQ-015 WAIT_DONE: proc_done SHALL be ignored on the first cycle after entry.
- Afterwards proc_done=1 SHALL latch proc_match into batch_match and proc_byte_pos into batch_byte_pos.
- It SHALL then enter READOUT if proc_match=1, else FINISH.
REQ-016 WAIT_DONE: a 16-bit cycle counter SHALL expire after DONE_TIMEOUT cycles without proc_done, set batch_timeout=1 and enter FINISH with batch_match=0.
- If proc_done and expiry coincide, proc_done SHALL win.
REQ-017 READOUT: res_valid SHALL be 1 and res_char SHALL equal proc_match_char.
- proc_match_char_next SHALL equal res_valid&res_ready, combinationally.
- A 5-bit char counter SHALL advance per handshake; after MSG_LEN handshakes the FSM SHALL enter FINISH.
REQ-018 FINISH: batch_done SHALL be 1 for one cycle, then the FSM SHALL return to IDLE.
REQ-019 batch_busy SHALL be 1 in every state except IDLE.
REQ-020 batch_match, batch_timeout and batch_byte_pos SHALL hold their values until the next accepted batch_start.

Reset
REQ-021 reset=1 SHALL force IDLE in any state, including mid-STREAM and mid-READOUT.
REQ-022 reset SHALL zero all counters and registered outputs: proc_data, proc_data_valid, proc_start, proc_num_bytes and all batch_* outputs.
REQ-023 During reset, src_ready, res_valid and proc_match_char_next SHALL be 0.

Configuration
REQ-024 With macro MD5_MATCH_READOUT_EN defined, READOUT SHALL behave per REQ-017.
REQ-025 Without MD5_MATCH_READOUT_EN:
- READOUT SHALL not exist and WAIT_DONE SHALL always proceed to FINISH.
- res_valid, res_char and proc_match_char_next SHALL be tied to 0.
- res_ready SHALL be unused.

Verification
REQ-026 N=5 with src_valid held 1 -> proc_start one cycle; proc_data_valid high for 5 consecutive cycles starting the cycle after the first accept; src_ready low after the 5th byte.
REQ-027 N=3 with src_valid toggling 1,0,1,0,1 -> exactly 3 proc_data_valid pulses, data in order.
REQ-028 proc_done with proc_match=1 and proc_byte_pos=0x0012 (MSG_LEN=19, res_ready=1) -> 19 proc_match_char_next pulses, then batch_done with batch_match=1 and batch_byte_pos=0x0012.
REQ-029 N=0 -> START then WAIT_DONE; proc_done=1, proc_match=0 -> batch_done with batch_match=0 and no res_valid.
REQ-030 DONE_TIMEOUT=8 with proc_done never asserted -> batch_done exactly 8 cycles after WAIT_DONE entry with batch_timeout=1.
REQ-031 reset asserted at the 10th READOUT character -> next cycle batch_busy=0 and res_valid=0; a new batch_start is accepted normally.

Source files
------------

// File: rtl/md5_batch_ctrl.sv
// md5_batch_ctrl -- sequences one batch through an MD5 match processor.
// The host starts a batch of N bytes; the block pulses proc_start, streams the
// bytes from a valid/ready source into the processor, waits (bounded) for
// proc_done, optionally reads out the matched string, and reports the result.
// Optional feature macro: MD5_MATCH_READOUT_EN enables the READOUT state and
// the res_* result stream. Without it the result stream is tied off.
module md5_batch_ctrl #(
  parameter int MSG_LEN      = 19,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  // host side
  input  logic        batch_start,
  input  logic [15:0] batch_num_bytes,
  output logic        batch_busy,
  output logic        batch_done,
  output logic        batch_match,
  output logic        batch_timeout,
  output logic [15:0] batch_byte_pos,
  // byte source stream
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  // matched-string result stream
  output logic [7:0]  res_char,
  output logic        res_valid,
  input  logic        res_ready,
  // processor side
  output logic        proc_start,
  output logic [15:0] proc_num_bytes,
  output logic [7:0]  proc_data,
  output logic        proc_data_valid,
  output logic        proc_match_char_next,
  input  logic        proc_done,
  input  logic        proc_match,
  input  logic [15:0] proc_byte_pos,
  input  logic [7:0]  proc_match_char
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_STREAM    = 3'd2,
    ST_WAIT_DONE = 3'd3,
`ifdef MD5_MATCH_READOUT_EN
    ST_READOUT   = 3'd4,
`endif
    ST_FINISH    = 3'd5
  } state_t;

  // Last value of each counter before the state is left.
  localparam logic [15:0] TIMEOUT_LAST = 16'(DONE_TIMEOUT - 1);
  localparam logic [4:0]  LAST_CHAR    = 5'(MSG_LEN - 1);

  state_t      state_q;
  logic [15:0] n_q;          // batch length latched at start
  logic [15:0] sent_q;       // bytes accepted from the source so far
  logic [15:0] wait_cnt_q;   // cycles spent in WAIT_DONE
  logic        busy_q;
  logic        done_q;
  logic        match_q;
  logic        timeout_q;
  logic [15:0] byte_pos_q;
  logic        proc_start_q;
  logic [15:0] proc_num_bytes_q;
  logic [7:0]  proc_data_q;
  logic        proc_data_valid_q;
`ifdef MD5_MATCH_READOUT_EN
  logic [4:0]  char_cnt_q;   // result characters handed over so far
`endif

  // Batch sequencer: state, counters and every registered output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      n_q               <= '0;
      sent_q            <= '0;
      wait_cnt_q        <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      match_q           <= 1'b0;
      timeout_q         <= 1'b0;
      byte_pos_q        <= '0;
      proc_start_q      <= 1'b0;
      proc_num_bytes_q  <= '0;
      proc_data_q       <= '0;
      proc_data_valid_q <= 1'b0;
`ifdef MD5_MATCH_READOUT_EN
      char_cnt_q        <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge value of each register regardless of statement order.
      proc_start_q      <= 1'b0;
      proc_data_valid_q <= 1'b0;
      done_q            <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (batch_start) begin
            n_q              <= batch_num_bytes;
            proc_num_bytes_q <= batch_num_bytes;
            proc_start_q     <= 1'b1;
            sent_q           <= '0;
            wait_cnt_q       <= '0;
            match_q          <= 1'b0;
            timeout_q        <= 1'b0;
            byte_pos_q       <= '0;
            busy_q           <= 1'b1;
`ifdef MD5_MATCH_READOUT_EN
            char_cnt_q       <= '0;
`endif
            state_q          <= ST_START;
          end
        end
        ST_START: begin
          state_q <= (n_q != 16'd0) ? ST_STREAM : ST_WAIT_DONE;
        end
        ST_STREAM: begin
          // src_ready is high throughout this state, so valid alone is a handshake.
          if (src_valid) begin
            proc_data_q       <= src_data;
            proc_data_valid_q <= 1'b1;
            sent_q            <= sent_q + 16'd1;
            if (sent_q + 16'd1 == n_q) state_q <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          // proc_done is not trusted on the entry cycle; it wins over expiry.
          if (wait_cnt_q != 16'd0 && proc_done) begin
            match_q    <= proc_match;
            byte_pos_q <= proc_byte_pos;
`ifdef MD5_MATCH_READOUT_EN
            if (proc_match) begin
              state_q <= ST_READOUT;
            end else begin
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
            end
`else
            state_q    <= ST_FINISH;
            done_q     <= 1'b1;
`endif
          end else if (wait_cnt_q == TIMEOUT_LAST) begin
            timeout_q <= 1'b1;
            match_q   <= 1'b0;
            state_q   <= ST_FINISH;
            done_q    <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end
`ifdef MD5_MATCH_READOUT_EN
        ST_READOUT: begin
          if (res_ready) begin
            char_cnt_q <= char_cnt_q + 5'd1;
            if (char_cnt_q == LAST_CHAR) begin
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
            end
          end
        end
`endif
        ST_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs are decoded from state and forced low while in reset,
  // because reset has not yet moved the state register on its first cycle.
  assign src_ready = !reset && (state_q == ST_STREAM);

`ifdef MD5_MATCH_READOUT_EN
  assign res_valid            = !reset && (state_q == ST_READOUT);
  assign res_char             = res_valid ? proc_match_char : 8'h00;
  assign proc_match_char_next = res_valid && res_ready;
`else
  assign res_valid            = 1'b0;
  assign res_char             = 8'h00;
  assign proc_match_char_next = 1'b0;
  // The result stream inputs have no consumer in this build.
  logic unused_readout;
  assign unused_readout = &{1'b0, res_ready, proc_match_char, LAST_CHAR};
`endif

  assign batch_busy      = busy_q;
  assign batch_done      = done_q;
  assign batch_match     = match_q;
  assign batch_timeout   = timeout_q;
  assign batch_byte_pos  = byte_pos_q;
  assign proc_start      = proc_start_q;
  assign proc_num_bytes  = proc_num_bytes_q;
  assign proc_data       = proc_data_q;
  assign proc_data_valid = proc_data_valid_q;

endmodule

// File: tb/tb_md5_batch_ctrl.sv
// tb_md5_batch_ctrl -- directed bench for md5_batch_ctrl (DONE_TIMEOUT=8).
// Table of whole-batch vectors plus hand sequences for exact timing and reset.
module tb_md5_batch_ctrl;

`ifdef MD5_MATCH_READOUT_EN
  localparam int RD_CHARS = 19;
`else
  localparam int RD_CHARS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        batch_start;
  logic [15:0] batch_num_bytes;
  logic        batch_busy, batch_done, batch_match, batch_timeout;
  logic [15:0] batch_byte_pos;
  logic [7:0]  src_data;
  logic        src_valid, src_ready;
  logic [7:0]  res_char;
  logic        res_valid, res_ready;
  logic        proc_start;
  logic [15:0] proc_num_bytes;
  logic [7:0]  proc_data;
  logic        proc_data_valid, proc_match_char_next;
  logic        proc_done, proc_match;
  logic [15:0] proc_byte_pos;
  logic [7:0]  proc_match_char;

  md5_batch_ctrl #(.MSG_LEN(19), .DONE_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .batch_start(batch_start), .batch_num_bytes(batch_num_bytes),
    .batch_busy(batch_busy), .batch_done(batch_done), .batch_match(batch_match),
    .batch_timeout(batch_timeout), .batch_byte_pos(batch_byte_pos),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .res_char(res_char), .res_valid(res_valid), .res_ready(res_ready),
    .proc_start(proc_start), .proc_num_bytes(proc_num_bytes), .proc_data(proc_data),
    .proc_data_valid(proc_data_valid), .proc_match_char_next(proc_match_char_next),
    .proc_done(proc_done), .proc_match(proc_match), .proc_byte_pos(proc_byte_pos),
    .proc_match_char(proc_match_char)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] n;
    logic [7:0]  valid_pat;   // src_valid per cycle, LSB first, repeating
    logic [7:0]  ready_pat;   // res_ready per cycle, LSB first, repeating
    logic        give_done;
    logic        match;
    logic [15:0] pos;
    logic        exp_match;
    logic        exp_timeout;
    logic [15:0] exp_pos;
    int          exp_chars;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations gathered mid-cycle, after inputs have settled.
  logic [7:0] obs_q[$];
  int hs_mon   = 0;
  int rv_mon   = 0;
  int char_err = 0;

  always @(negedge clk) begin
    #2;
    if (proc_data_valid) obs_q.push_back(proc_data);
    if (proc_match_char_next) hs_mon++;
    if (res_valid) begin
      rv_mon++;
      if (res_char !== proc_match_char) char_err++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full batch driven by a table vector, then end-of-batch checks.
  task automatic run_batch(input vec_t v, input int idx);
    int sent = 0;
    int k = 0;
    int hs = 0;
    int base, hs0, rv0, ce0;
    logic seen = 1'b0;
    logic [7:0] exp_bytes[$];
    base = obs_q.size(); hs0 = hs_mon; rv0 = rv_mon; ce0 = char_err;
    @(negedge clk); batch_start = 1'b1; batch_num_bytes = v.n;
    @(negedge clk); batch_start = 1'b0;
    while (sent < int'(v.n) && k < 200) begin
      @(negedge clk);
      src_valid = v.valid_pat[k % 8];
      src_data  = 8'(32 + idx * 16 + sent);
      #1;
      if (src_valid && src_ready) begin
        exp_bytes.push_back(src_data);
        sent++;
      end
      k++;
    end
    check("vec_bytes_accepted", sent, v.n);
    @(negedge clk); src_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); proc_done = v.give_done; proc_match = v.match; proc_byte_pos = v.pos;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      proc_done = 1'b0;
      res_ready = v.ready_pat[c % 8];
      proc_match_char = 8'(65 + hs);
      #1;
      if (proc_match_char_next) hs++;
      if (batch_done) seen = 1'b1;
    end
    check("vec_done_seen", seen, 1);
    check("vec_match", batch_match, v.exp_match);
    check("vec_timeout", batch_timeout, v.exp_timeout);
    check("vec_byte_pos", batch_byte_pos, v.exp_pos);
    check("vec_busy_in_finish", batch_busy, 1);
    @(negedge clk); res_ready = 1'b0; #1;
    check("vec_idle_busy", batch_busy, 0);
    check("vec_done_one_cycle", batch_done, 0);
    check("vec_pos_held", batch_byte_pos, v.exp_pos);
    check("vec_data_count", obs_q.size() - base, v.n);
    for (int i = 0; i < exp_bytes.size() && base + i < obs_q.size(); i++)
      check("vec_data_order", obs_q[base + i], exp_bytes[i]);
    check("vec_char_pulses", hs_mon - hs0, v.exp_chars);
    check("vec_res_char", char_err - ce0, 0);
    if (v.exp_chars == 0) check("vec_no_res_valid", rv_mon - rv0, 0);
  endtask

  // N=0 batch; proc_done optionally pulsed on wait cycle done_at (-1 = never).
  task automatic timed_wait(input string tag, input int done_at, input logic [15:0] pos,
                            input logic exp_to, input logic [15:0] exp_pos);
    int seen_at = -1;
    @(negedge clk); batch_start = 1'b1; batch_num_bytes = 16'd0;
    @(negedge clk); batch_start = 1'b0; #1;
    check({tag, "_proc_start"}, proc_start, 1);
    for (int c = 0; c < 20 && seen_at < 0; c++) begin
      @(negedge clk);
      proc_done = (c == done_at); proc_match = 1'b0; proc_byte_pos = pos;
      #1;
      if (batch_done) seen_at = c;
    end
    check({tag, "_done_cycle"}, seen_at, 8);
    check({tag, "_timeout"}, batch_timeout, exp_to);
    check({tag, "_match"}, batch_match, 0);
    check({tag, "_byte_pos"}, batch_byte_pos, exp_pos);
    @(negedge clk); proc_done = 1'b0; #1;
    check({tag, "_idle"}, batch_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{n:16'd3, valid_pat:8'b0001_0101, ready_pat:8'hFF, give_done:1'b1, match:1'b0,
                pos:16'h0003, exp_match:1'b0, exp_timeout:1'b0, exp_pos:16'h0003, exp_chars:0};
    vecs[1] = '{n:16'd1, valid_pat:8'hFF, ready_pat:8'hFF, give_done:1'b1, match:1'b1,
                pos:16'h0012, exp_match:1'b1, exp_timeout:1'b0, exp_pos:16'h0012, exp_chars:RD_CHARS};
    vecs[2] = '{n:16'd0, valid_pat:8'hFF, ready_pat:8'hFF, give_done:1'b1, match:1'b0,
                pos:16'h0000, exp_match:1'b0, exp_timeout:1'b0, exp_pos:16'h0000, exp_chars:0};
    vecs[3] = '{n:16'd4, valid_pat:8'b0000_0011, ready_pat:8'hFF, give_done:1'b0, match:1'b1,
                pos:16'h1234, exp_match:1'b0, exp_timeout:1'b1, exp_pos:16'h0000, exp_chars:0};
    vecs[4] = '{n:16'd2, valid_pat:8'hFF, ready_pat:8'b1001_0110, give_done:1'b1, match:1'b1,
                pos:16'hBEEF, exp_match:1'b1, exp_timeout:1'b0, exp_pos:16'hBEEF, exp_chars:RD_CHARS};
    vecs[5] = '{n:16'd0, valid_pat:8'hFF, ready_pat:8'hFF, give_done:1'b0, match:1'b0,
                pos:16'h0000, exp_match:1'b0, exp_timeout:1'b1, exp_pos:16'h0000, exp_chars:0};
    vecs[6] = '{n:16'd7, valid_pat:8'b1110_1110, ready_pat:8'hFF, give_done:1'b1, match:1'b0,
                pos:16'h0100, exp_match:1'b0, exp_timeout:1'b0, exp_pos:16'h0100, exp_chars:0};

    reset = 1'b1; batch_start = 1'b0; batch_num_bytes = '0;
    src_data = '0; src_valid = 1'b0; res_ready = 1'b0;
    proc_done = 1'b0; proc_match = 1'b0; proc_byte_pos = '0; proc_match_char = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", batch_busy, 0);
    check("rst_done", batch_done, 0);
    check("rst_flags", {batch_match, batch_timeout}, 0);
    check("rst_byte_pos", batch_byte_pos, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_proc_regs", {proc_start, proc_num_bytes, proc_data, proc_data_valid}, 0);
    @(negedge clk); reset = 1'b0;

    // N=5 with src_valid held: exact start pulse and data-valid window.
    @(negedge clk); batch_start = 1'b1; batch_num_bytes = 16'd5;
    @(negedge clk); batch_start = 1'b0; src_valid = 1'b1; src_data = 8'h10; #1;
    check("n5_proc_start", proc_start, 1);
    check("n5_proc_num_bytes", proc_num_bytes, 5);
    check("n5_ready_in_start", src_ready, 0);
    check("n5_busy", batch_busy, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      src_data = 8'(16 + i);
      batch_start = (i == 2);        // must be ignored outside IDLE
      batch_num_bytes = (i == 2) ? 16'd9 : 16'd5;
      #1;
      check("n5_src_ready", src_ready, 1);
      check("n5_pdv", proc_data_valid, (i > 0));
      if (i == 0) check("n5_start_one_cycle", proc_start, 0);
      else        check("n5_proc_data", proc_data, 16 + i - 1);
    end
    @(negedge clk); src_valid = 1'b0; batch_start = 1'b0; #1;
    check("n5_ready_dropped", src_ready, 0);
    check("n5_pdv_last", proc_data_valid, 1);
    check("n5_proc_data_last", proc_data, 8'h14);
    @(negedge clk); #1;
    check("n5_pdv_off", proc_data_valid, 0);
    check("n5_proc_data_hold", proc_data, 8'h14);
    check("n5_num_bytes_kept", proc_num_bytes, 5);
    @(negedge clk); proc_done = 1'b1; proc_match = 1'b0; proc_byte_pos = 16'h0007;
    @(negedge clk); proc_done = 1'b0; #1;
    check("n5_done", batch_done, 1);
    check("n5_byte_pos", batch_byte_pos, 16'h0007);
    @(negedge clk); #1;
    check("n5_idle", batch_busy, 0);

    // WAIT_DONE bound: expiry, entry-cycle done ignored, done on expiry cycle wins.
    timed_wait("to_none", -1, 16'h0000, 1'b1, 16'h0000);
    timed_wait("to_entry_done", 0, 16'h0033, 1'b1, 16'h0000);
    timed_wait("to_tie_done", 7, 16'h0055, 1'b0, 16'h0055);

    // Reset in the middle of STREAM.
    @(negedge clk); batch_start = 1'b1; batch_num_bytes = 16'd10;
    @(negedge clk); batch_start = 1'b0; src_valid = 1'b1; src_data = 8'h77;
    repeat (4) @(negedge clk);
    @(negedge clk); reset = 1'b1; #1;
    check("rs_ready_in_reset", src_ready, 0);
    @(negedge clk); reset = 1'b0; src_valid = 1'b0; #1;
    check("rs_busy", batch_busy, 0);
    check("rs_pdv", proc_data_valid, 0);
    check("rs_proc_data", proc_data, 0);
    check("rs_src_ready", src_ready, 0);

`ifdef MD5_MATCH_READOUT_EN
    // Reset on the 10th result character.
    begin
      int hs = 0;
      logic fired = 1'b0;
      @(negedge clk); batch_start = 1'b1; batch_num_bytes = 16'd1;
      @(negedge clk); batch_start = 1'b0; src_valid = 1'b1; src_data = 8'h5A;
      @(negedge clk);
      @(negedge clk); src_valid = 1'b0;
      @(negedge clk);
      @(negedge clk); proc_done = 1'b1; proc_match = 1'b1; proc_byte_pos = 16'h0012;
      for (int c = 0; c < 40 && !fired; c++) begin
        @(negedge clk);
        proc_done = 1'b0; res_ready = 1'b1; proc_match_char = 8'(65 + hs);
        if (hs == 9) begin
          reset = 1'b1; #1;
          check("rr_res_valid_in_reset", res_valid, 0);
          check("rr_next_in_reset", proc_match_char_next, 0);
          fired = 1'b1;
        end else begin
          #1;
          if (proc_match_char_next) hs++;
        end
      end
      check("rr_reached_char10", fired, 1);
      @(negedge clk); reset = 1'b0; res_ready = 1'b0; #1;
      check("rr_busy", batch_busy, 0);
      check("rr_res_valid", res_valid, 0);
      check("rr_done", batch_done, 0);
    end
`endif

    for (int i = 0; i < 7; i++) run_batch(vecs[i], i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
